// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Response payload, boot image words and the access-error rule.
package dmem_pkg;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } dmem_rsp_t;

    localparam logic [31:0] DMEM_INIT_W0 = 32'hDEAD_BEEF;
    localparam logic [31:0] DMEM_INIT_W1 = 32'h1234_5678;
    localparam logic [31:0] DMEM_INIT_W2 = 32'h0000_0000;
    localparam logic [31:0] DMEM_INIT_W3 = 32'hFEDC_BA98;

    // Full-width index compare so large addresses never alias low words.
    function automatic logic is_err(input logic [31:0] addr,
                                    input int unsigned depth);
        return (addr[1:0] != 2'b00) || (32'(addr[31:2]) >= depth);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channels between the memory stage and the responder.
// master = initiator (pipeline), slave = responder.
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_responder_rsp_fifo.sv
// In-order response queue; depth equals the credit limit of the
// responder, so it is never pushed while full.
module dmem_rsp_fifo
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  dmem_rsp_t push_data,
    input  logic      pop,
    output dmem_rsp_t head,
    output logic      empty,
    output logic      full
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    dmem_rsp_t     slots [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign head  = slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) slots[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dmem_responder.sv
// Word-addressed data memory with fixed-latency, credit-limited,
// in-order responses for the pipeline memory stage.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned OUTSTANDING = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW = $clog2(OUTSTANDING + 1);

    // Boot image lives on the array itself so reset leaves contents intact.
    logic [31:0] mem [DEPTH_WORDS] = '{
        0: DMEM_INIT_W0, 1: DMEM_INIT_W1,
        2: DMEM_INIT_W2, 3: DMEM_INIT_W3,
        default: '0
    };

    logic [CW-1:0]              credits;
    logic                       acc;
    logic                       acc_err;
    logic                       pop;
    logic [IW-1:0]              idx;
    logic [31:0]                wr_word;
    dmem_rsp_t                  acc_rsp;
    logic [LATENCY-1:0]         dl_vld;
    dmem_rsp_t [LATENCY-1:0]    dl_rsp;
    dmem_rsp_t                  head;
    logic                       empty;
    logic                       full;
    logic                       unused_full;

    assign idx           = bus.req_addr[IW+1:2];
    assign acc_err       = is_err(bus.req_addr, DEPTH_WORDS);
    assign bus.req_ready = !reset && (credits < CW'(OUTSTANDING));
    assign acc           = bus.req_valid && bus.req_ready;
    assign pop           = bus.rsp_valid && bus.rsp_ready;

    always_comb begin
        acc_rsp     = '0;
        acc_rsp.err = acc_err;
        if (!bus.req_we && !acc_err) acc_rsp.rdata = mem[idx];
    end

    always_comb begin
        wr_word = mem[idx];
        for (int i = 0; i < 4; i++) begin
            if (bus.req_be[i]) wr_word[8*i +: 8] = bus.req_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (acc && bus.req_we && !acc_err) mem[idx] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dl_vld  <= '0;
            credits <= '0;
        end else begin
            dl_vld[0] <= acc;
            for (int s = 1; s < LATENCY; s++) dl_vld[s] <= dl_vld[s-1];
            credits <= credits + CW'(acc) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        dl_rsp[0] <= acc_rsp;
        for (int s = 1; s < LATENCY; s++) dl_rsp[s] <= dl_rsp[s-1];
    end

    dmem_rsp_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (dl_vld[LATENCY-1]),
        .push_data (dl_rsp[LATENCY-1]),
        .pop       (pop),
        .head      (head),
        .empty     (empty),
        .full      (full)
    );

    assign bus.rsp_valid = !empty;
    assign bus.rsp_rdata = empty ? '0 : head.rdata;
    assign bus.rsp_err   = !empty && head.err;
    assign unused_full   = full;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table, directed corner sequences and
// random traffic against a queue/array reference model.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int LAT   = 2;
    localparam int OUT   = 2;
    localparam int DEPTH = 256;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] mem_m [DEPTH];
    exp_t        q[$];
    logic [32:0] got[$];
    logic        last_acc;
    vec_t        vt [13];

    dmem_responder_if b1 ();
    dmem_responder_if b3 ();

    dmem_responder #(
        .DEPTH_WORDS (256),
        .LATENCY     (2),
        .OUTSTANDING (2)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    dmem_responder #(
        .DEPTH_WORDS (256),
        .LATENCY     (2),
        .OUTSTANDING (3)
    ) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (b3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] a,
                       input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic chk1(input string n, input logic a, input logic e);
        chk(n, 64'(a), 64'(e));
    endtask

    task automatic chk32(input string n, input logic [31:0] a,
                         input logic [31:0] e);
        chk(n, 64'(a), 64'(e));
    endtask

    task automatic chkn(input string n, input int a, input int e);
        chk(n, 64'(a), 64'(e));
    endtask

    task automatic check_outputs();
        logic ev;
        ev = (q.size() > 0) && (q[0].due <= cyc);
        chk1("req_ready", b1.req_ready, q.size() < OUT);
        chk1("rsp_valid", b1.rsp_valid, ev);
        if (ev && b1.rsp_valid) begin
            chk32("rsp_rdata", b1.rsp_rdata, q[0].rdata);
            chk1("rsp_err", b1.rsp_err, q[0].err);
        end
    endtask

    // One clock of traffic on b1; the model advances with it.
    task automatic step(input logic v, input logic we,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input logic rr);
        exp_t        e;
        logic        ev, acc, pop, err;
        logic [31:0] w;
        b1.req_valid = v;
        b1.req_we    = we;
        b1.req_addr  = a;
        b1.req_wdata = wd;
        b1.req_be    = be;
        b1.rsp_ready = rr;
        ev  = (q.size() > 0) && (q[0].due <= cyc);
        acc = v && (q.size() < OUT);
        pop = ev && rr;
        if (pop) begin
            got.push_back({b1.rsp_rdata, b1.rsp_err});
            void'(q.pop_front());
        end
        if (acc) begin
            err     = (a[1:0] != 2'b00) || (32'(a[31:2]) >= 32'(DEPTH));
            e.err   = err;
            e.rdata = '0;
            e.due   = cyc + 1 + LAT;
            if (!err) begin
                w = mem_m[a[9:2]];
                if (we) begin
                    for (int i = 0; i < 4; i++)
                        if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
                    mem_m[a[9:2]] = w;
                end else begin
                    e.rdata = w;
                end
            end
            q.push_back(e);
        end
        last_acc = acc;
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n, input logic rr);
        repeat (n) step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rr);
    endtask

    task automatic send(input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic rr);
        int n;
        n = 0;
        last_acc = 1'b0;
        while (!last_acc && n < 40) begin
            step(1'b1, we, a, wd, be, rr);
            n++;
        end
        chk1("send_accept", last_acc, 1'b1);
    endtask

    task automatic do_reset(input int n);
        b1.req_valid = 1'b0;
        b1.rsp_ready = 1'b0;
        reset = 1'b1;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            chk1("rst_req_ready", b1.req_ready, 1'b0);
            chk1("rst_rsp_valid", b1.rsp_valid, 1'b0);
            chk32("rst_rsp_rdata", b1.rsp_rdata, 32'h0);
            chk1("rst_rsp_err", b1.rsp_err, 1'b0);
        end
        q.delete();
        got.delete();
        reset = 1'b0;
        idle(1, 1'b1);
    endtask

    initial begin
        logic [32:0] hold;
        logic [31:0] rnd;
        logic [31:0] a;
        logic [31:0] addrs [3];
        logic [31:0] datas [3];
        int          r, k, n;

        for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
        mem_m[0] = 32'hDEADBEEF;
        mem_m[1] = 32'h12345678;
        mem_m[3] = 32'hFEDCBA98;

        b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_addr = 32'h0;
        b1.req_wdata = 32'h0; b1.req_be = 4'h0; b1.rsp_ready = 1'b0;
        b3.req_valid = 1'b0; b3.req_we = 1'b0; b3.req_addr = 32'h0;
        b3.req_wdata = 32'h0; b3.req_be = 4'h0; b3.rsp_ready = 1'b1;

        vt[0]  = '{1'b0, 32'h0000_0000, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0};
        vt[1]  = '{1'b0, 32'h0000_0004, 32'h0, 4'h0, 32'h12345678, 1'b0};
        vt[2]  = '{1'b0, 32'h0000_000C, 32'h0, 4'h0, 32'hFEDCBA98, 1'b0};
        vt[3]  = '{1'b0, 32'h0000_0002, 32'h0, 4'h0, 32'h0, 1'b1};
        vt[4]  = '{1'b1, 32'h0000_0400, 32'h11223344, 4'hF, 32'h0, 1'b1};
        vt[5]  = '{1'b0, 32'h0000_0000, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0};
        vt[6]  = '{1'b0, 32'h0000_03FC, 32'h0, 4'h0, 32'h0, 1'b0};
        vt[7]  = '{1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'h0, 1'b1};
        vt[8]  = '{1'b1, 32'h0000_03FC, 32'hFFFFFFFF, 4'h8, 32'h0, 1'b0};
        vt[9]  = '{1'b0, 32'h0000_03FC, 32'h0, 4'h0, 32'hFF000000, 1'b0};
        vt[10] = '{1'b0, 32'h0000_0401, 32'h0, 4'h0, 32'h0, 1'b1};
        vt[11] = '{1'b1, 32'h0000_0003, 32'h55555555, 4'hF, 32'h0, 1'b1};
        vt[12] = '{1'b0, 32'h0000_0000, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0};

        do_reset(2);

        // Single requests from the table, each fully drained.
        for (int i = 0; i < 13; i++) begin
            got.delete();
            send(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, 1'b1);
            k = 1;
            while (!b1.rsp_valid && k < 20) begin
                idle(1, 1'b1);
                k++;
            end
            chkn("vec_latency", k, LAT + 1);
            idle(1, 1'b1);
            chkn("vec_pops", got.size(), 1);
            if (got.size() == 1) begin
                chk32("vec_rdata", got[0][32:1], vt[i].exp_rdata);
                chk1("vec_err", got[0][0], vt[i].exp_err);
            end
        end

        // Store then load of the same word on consecutive cycles.
        got.delete();
        send(1'b1, 32'h8, 32'hA5A5A5A5, 4'b0101, 1'b1);
        send(1'b0, 32'h8, 32'h0, 4'h0, 1'b1);
        send(1'b1, 32'h8, 32'h5A5A5A5A, 4'b1010, 1'b1);
        send(1'b0, 32'h8, 32'h0, 4'h0, 1'b1);
        idle(8, 1'b1);
        chkn("raw_pops", got.size(), 4);
        if (got.size() == 4) begin
            chk("raw_store1", 64'(got[0]), 64'({32'h0, 1'b0}));
            chk("raw_load1", 64'(got[1]), 64'({32'h00A500A5, 1'b0}));
            chk("raw_store2", 64'(got[2]), 64'({32'h0, 1'b0}));
            chk("raw_load2", 64'(got[3]), 64'({32'h5AA55AA5, 1'b0}));
        end

        // Credit exhaustion with a stalled consumer.
        got.delete();
        send(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        send(1'b0, 32'h4, 32'h0, 4'h0, 1'b0);
        chk1("full_req_ready", b1.req_ready, 1'b0);
        repeat (3) step(1'b1, 1'b0, 32'hC, 32'h0, 4'h0, 1'b0);
        chk1("stall_valid", b1.rsp_valid, 1'b1);
        hold = {b1.rsp_rdata, b1.rsp_err};
        chk("stall_head", 64'(hold), 64'({32'hDEADBEEF, 1'b0}));
        repeat (3) begin
            step(1'b1, 1'b0, 32'hC, 32'h0, 4'h0, 1'b0);
            chk1("stall_no_accept", last_acc, 1'b0);
            chk("stall_hold", 64'({b1.rsp_rdata, b1.rsp_err}), 64'(hold));
        end
        n = 0;
        last_acc = 1'b0;
        while (!last_acc && n < 20) begin
            step(1'b1, 1'b0, 32'hC, 32'h0, 4'h0, 1'b1);
            n++;
        end
        chk1("third_accept", last_acc, 1'b1);
        chk1("popped_before_third", got.size() >= 1, 1'b1);
        idle(8, 1'b1);
        chkn("stall_pops", got.size(), 3);
        if (got.size() == 3) begin
            chk32("stall_order0", got[0][32:1], 32'hDEADBEEF);
            chk32("stall_order1", got[1][32:1], 32'h12345678);
            chk32("stall_order2", got[2][32:1], 32'hFEDCBA98);
        end

        // Reset with loads in flight; memory must survive.
        send(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        send(1'b0, 32'h4, 32'h0, 4'h0, 1'b1);
        do_reset(2);
        idle(6, 1'b1);
        chkn("no_stale_rsp", got.size(), 0);
        send(1'b0, 32'h8, 32'h0, 4'h0, 1'b1);
        idle(6, 1'b1);
        chkn("post_rst_pops", got.size(), 1);
        if (got.size() == 1)
            chk32("mem_kept", got[0][32:1], 32'h5AA55AA5);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            rnd = $urandom;
            r = $urandom_range(0, 9);
            if (r < 7)       a = {22'h0, rnd[7:0], 2'b00};
            else if (r == 7) a = {22'h0, rnd[9:0]};
            else if (r == 8) a = 32'h400 + {18'h0, rnd[11:0], 2'b00};
            else             a = rnd;
            step($urandom_range(0, 3) != 0, rnd[31], a, $urandom,
                 4'($urandom), $urandom_range(0, 3) != 0);
        end
        idle(10, 1'b1);

        // Back-to-back loads with three credits.
        addrs[0] = 32'h0;        addrs[1] = 32'h4;        addrs[2] = 32'hC;
        datas[0] = 32'hDEADBEEF; datas[1] = 32'h12345678; datas[2] = 32'hFEDCBA98;
        b3.rsp_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if (j < 3) begin
                b3.req_valid = 1'b1;
                b3.req_addr  = addrs[j];
                chk1("b2b_req_ready", b3.req_ready, 1'b1);
            end else begin
                b3.req_valid = 1'b0;
            end
            if (j >= 3 && j <= 5) begin
                chk1("b2b_rsp_valid", b3.rsp_valid, 1'b1);
                chk32("b2b_rsp_rdata", b3.rsp_rdata, datas[j-3]);
                chk1("b2b_rsp_err", b3.rsp_err, 1'b0);
            end else begin
                chk1("b2b_rsp_idle", b3.rsp_valid, 1'b0);
            end
            @(posedge clk);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
